// File: rtl/ssp_reg_arbiter.sv
// ssp_reg_arbiter: two-requester arbiter sequencing accesses onto the ssp_uart register port.
// Define SSP_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ssp_reg_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        WnR0,
    input  logic        WnR1,
    input  logic [2:0]  RA0,
    input  logic [2:0]  RA1,
    input  logic [11:0] DI0,
    input  logic [11:0] DI1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [11:0] RdData,
    output logic [1:0]  Gnt,
    output logic        Busy,
    output logic        SSP_SSEL,
    output logic        SSP_EOC,
    output logic        SSP_WnR,
    output logic [2:0]  SSP_RA,
    output logic [11:0] SSP_DI,
    input  logic [11:0] SSP_DO
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, DONE} state_t;
    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       pick1;
    logic       grant;
    assign grant = (state == IDLE) && (Req0 || Req1);
`ifdef SSP_ARB_RR_EN
    // last1 remembers who won the previous grant; reset favours requester 0
    logic last1;
    always_ff @(posedge Clk) begin
        if (Rst)
            last1 <= 1'b1;
        else if (grant)
            last1 <= pick1;
    end
    assign pick1 = Req1 && (!Req0 || !last1);
`else
    assign pick1 = Req1 && !Req0;
`endif
    always_ff @(posedge Clk) begin
        state <= Rst ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (Req0 || Req1) ? SETUP : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    state_nxt = (cnt == 3'd1) ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Gnt     <= '0;
            SSP_WnR <= 1'b0;
            SSP_RA  <= '0;
            SSP_DI  <= '0;
            RdData  <= '0;
            cnt     <= '0;
        end else begin
            if (grant) begin
                Gnt     <= pick1 ? 2'b10 : 2'b01;
                SSP_WnR <= pick1 ? WnR1 : WnR0;
                SSP_RA  <= pick1 ? RA1 : RA0;
                SSP_DI  <= pick1 ? DI1 : DI0;
            end
            if (state == DONE)
                Gnt <= '0;
            if (state == ACCESS)
                cnt <= 3'(WAIT_CYCLES);
            else if (state == WAIT)
                cnt <= cnt - 3'd1;
            if (state == WAIT && cnt == 3'd1)
                RdData <= SSP_DO;
        end
    end
    assign Busy     = (state != IDLE);
    assign SSP_SSEL = (state == SETUP) || (state == ACCESS) || (state == WAIT);
    assign SSP_EOC  = (state == ACCESS);
    assign Ack0     = (state == DONE) && Gnt[0];
    assign Ack1     = (state == DONE) && Gnt[1];
endmodule

// File: tb/tb_ssp_reg_arbiter.sv
// tb_ssp_reg_arbiter: scoreboard bench for ssp_reg_arbiter, default and WAIT_CYCLES=4 instances.
// A register-echo model of ssp_uart answers the default instance.
module tb_ssp_reg_arbiter;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, WnR0 = 1'b0, WnR1 = 1'b0;
    logic [2:0]  RA0 = '0, RA1 = '0;
    logic [11:0] DI0 = '0, DI1 = '0;
    logic        Ack0, Ack1, Busy, SSP_SSEL, SSP_EOC, SSP_WnR;
    logic [11:0] RdData, SSP_DI, SSP_DO;
    logic [1:0]  Gnt;
    logic [2:0]  SSP_RA;
    logic        Ack0_4, Ack1_4, Busy_4, SSEL_4, EOC_4, WnR_4;
    logic [11:0] RdData_4, DI_4, DO_4;
    logic [1:0]  Gnt_4;
    logic [2:0]  RA_4;
    logic [11:0] regs [8];
    int          cyc = 0;
    int          viol = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    typedef struct packed {
        logic        who;
        logic [11:0] rd;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    ssp_reg_arbiter dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .WnR0(WnR0), .WnR1(WnR1),
        .RA0(RA0), .RA1(RA1), .DI0(DI0), .DI1(DI1), .Ack0(Ack0), .Ack1(Ack1),
        .RdData(RdData), .Gnt(Gnt), .Busy(Busy), .SSP_SSEL(SSP_SSEL), .SSP_EOC(SSP_EOC),
        .SSP_WnR(SSP_WnR), .SSP_RA(SSP_RA), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
    );

    ssp_reg_arbiter #(.WAIT_CYCLES(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .WnR0(WnR0), .WnR1(WnR1),
        .RA0(RA0), .RA1(RA1), .DI0(DI0), .DI1(DI1), .Ack0(Ack0_4), .Ack1(Ack1_4),
        .RdData(RdData_4), .Gnt(Gnt_4), .Busy(Busy_4), .SSP_SSEL(SSEL_4), .SSP_EOC(EOC_4),
        .SSP_WnR(WnR_4), .SSP_RA(RA_4), .SSP_DI(DI_4), .SSP_DO(DO_4)
    );

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Rst) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= (i == 3) ? 12'h5A5 : 12'h000;
        end else if (SSP_EOC && SSP_WnR) begin
            regs[SSP_RA] <= SSP_DI;
        end
    end
    assign SSP_DO = regs[SSP_RA];
    assign DO_4   = 12'(cyc);

    always @(negedge Clk) begin
        if ((Ack0 && Ack1) || Gnt == 2'b11 || (Ack0_4 && Ack1_4) || Gnt_4 == 2'b11)
            viol <= viol + 1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ack(input int maxk, output int k, output int who);
        k = 0;
        while (!(Ack0 || Ack1) && k < maxk) begin
            step();
            k++;
        end
        who = Ack1 ? 1 : (Ack0 ? 0 : -1);
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_checks++;
        if ({Ack0, Ack1, Gnt, Busy, SSP_SSEL, SSP_EOC, SSP_WnR} !== 8'b0)
            $display("FAIL reset_ctrl: got %b want 00000000", {Ack0, Ack1, Gnt, Busy, SSP_SSEL, SSP_EOC, SSP_WnR});
        else
            n_pass++;
        n_checks++;
        if ({SSP_RA, SSP_DI, RdData} !== 27'b0)
            $display("FAIL reset_data: ra %h di %h rd %h want 0", SSP_RA, SSP_DI, RdData);
        else
            n_pass++;
    endtask

    task automatic test_write();
        int k, who;
        exp_t e;
        Req0 = 1'b1; WnR0 = 1'b1; RA0 = 3'd0; DI0 = 12'hDED;
        sb.push_back('{who: 1'b0, rd: 12'hDED});
        step();
        n_checks++;
        if ({Gnt, SSP_SSEL, SSP_EOC, SSP_WnR, Busy} !== 6'b011011)
            $display("FAIL wr_setup: gnt/ssel/eoc/wnr/busy %b want 011011", {Gnt, SSP_SSEL, SSP_EOC, SSP_WnR, Busy});
        else
            n_pass++;
        step();
        n_checks++;
        if (SSP_EOC !== 1'b1 || SSP_DI !== 12'hDED)
            $display("FAIL wr_eoc: eoc %b di %h want 1 ded", SSP_EOC, SSP_DI);
        else
            n_pass++;
        wait_ack(10, k, who);
        n_checks++;
        if (k + 2 !== 5)
            $display("FAIL wr_ack_latency: got %0d want 5", k + 2);
        else
            n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (who !== int'(e.who) || RdData !== e.rd)
            $display("FAIL wr_sb: who %0d rd %h want %0d %h", who, RdData, e.who, e.rd);
        else
            n_pass++;
        Req0 = 1'b0;
        step();
        n_checks++;
        if ({Ack0, Busy, Gnt, SSP_SSEL, SSP_EOC} !== 6'b0 || SSP_DI !== 12'hDED || SSP_RA !== 3'd0 || RdData !== 12'hDED)
            $display("FAIL wr_idle_hold: ack %b busy %b gnt %b ssel %b di %h rd %h", Ack0, Busy, Gnt, SSP_SSEL, SSP_DI, RdData);
        else
            n_pass++;
    endtask

    task automatic test_read();
        int k, who;
        exp_t e;
        Req1 = 1'b1; WnR1 = 1'b0; RA1 = 3'd3;
        sb.push_back('{who: 1'b1, rd: 12'h5A5});
        step();
        n_checks++;
        if (SSP_WnR !== 1'b0 || SSP_RA !== 3'd3 || Gnt !== 2'b10)
            $display("FAIL rd_setup: wnr %b ra %0d gnt %b want 0 3 10", SSP_WnR, SSP_RA, Gnt);
        else
            n_pass++;
        wait_ack(10, k, who);
        n_checks++;
        if (k + 1 !== 5)
            $display("FAIL rd_ack_latency: got %0d want 5", k + 1);
        else
            n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (who !== int'(e.who) || RdData !== e.rd || Ack0 !== 1'b0)
            $display("FAIL rd_sb: who %0d rd %h ack0 %b want %0d %h 0", who, RdData, Ack0, e.who, e.rd);
        else
            n_pass++;
        Req1 = 1'b0;
        step();
    endtask

    task automatic test_tie();
        int k, who;
        exp_t e;
        pulse_reset();
        Req0 = 1'b1; WnR0 = 1'b1; RA0 = 3'd1; DI0 = 12'h111;
        Req1 = 1'b1; WnR1 = 1'b1; RA1 = 3'd2; DI1 = 12'h222;
        for (int i = 0; i < 4; i++) begin
`ifdef SSP_ARB_RR_EN
            sb.push_back((i % 2 == 1) ? exp_t'({1'b1, 12'h222}) : exp_t'({1'b0, 12'h111}));
`else
            sb.push_back(exp_t'({1'b0, 12'h111}));
`endif
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack(10, k, who);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL tie_sb_empty: grant %0d with no expectation", i);
            end else begin
                e = sb.pop_front();
                if (who !== int'(e.who) || RdData !== e.rd)
                    $display("FAIL tie_order_%0d: who %0d rd %h want %0d %h", i, who, RdData, e.who, e.rd);
                else
                    n_pass++;
            end
            if (i < 3)
                step();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        int k, who;
        int acks = 0;
        exp_t e;
        Req0 = 1'b1; WnR0 = 1'b1; RA0 = 3'd4; DI0 = 12'hABC;
        step();
        step();
        n_checks++;
        if (SSP_EOC !== 1'b1)
            $display("FAIL abort_in_access: eoc %b want 1", SSP_EOC);
        else
            n_pass++;
        Rst = 1'b1; Req0 = 1'b0;
        step();
        Rst = 1'b0;
        n_checks++;
        if ({Busy, SSP_SSEL, Gnt} !== 4'b0 || RdData !== 12'h000)
            $display("FAIL abort_idle: busy %b ssel %b gnt %b rd %h want 0", Busy, SSP_SSEL, Gnt, RdData);
        else
            n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (Ack0 || Ack1)
                acks++;
            step();
        end
        n_checks++;
        if (acks !== 0)
            $display("FAIL abort_no_ack: got %0d acks want 0", acks);
        else
            n_pass++;
        Req0 = 1'b1; WnR0 = 1'b0; RA0 = 3'd3;
        sb.push_back('{who: 1'b0, rd: 12'h5A5});
        step();
        Req0 = 1'b0;
        wait_ack(10, k, who);
        e = sb.pop_front();
        n_checks++;
        if (k + 1 !== 5 || who !== int'(e.who) || RdData !== e.rd)
            $display("FAIL abort_fresh: lat %0d who %0d rd %h want 5 %0d %h", k + 1, who, RdData, e.who, e.rd);
        else
            n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int k, who;
        exp_t e;
        Req0 = 1'b1; WnR0 = 1'b1; RA0 = 3'd5; DI0 = 12'h3C3;
        sb.push_back('{who: 1'b0, rd: 12'h3C3});
        step();
        step();
        step();
        RA0 = 3'd6; DI0 = 12'h0F0;
        sb.push_back('{who: 1'b0, rd: 12'h0F0});
        step();
        n_checks++;
        if (SSP_RA !== 3'd5 || SSP_DI !== 12'h3C3)
            $display("FAIL b2b_hold: ra %0d di %h want 5 3c3", SSP_RA, SSP_DI);
        else
            n_pass++;
        wait_ack(10, k, who);
        e = sb.pop_front();
        n_checks++;
        if (k + 4 !== 5 || who !== int'(e.who) || RdData !== e.rd)
            $display("FAIL b2b_first: lat %0d who %0d rd %h want 5 %0d %h", k + 4, who, RdData, e.who, e.rd);
        else
            n_pass++;
        step();
        n_checks++;
        if (Busy !== 1'b0)
            $display("FAIL b2b_idle: busy %b want 0", Busy);
        else
            n_pass++;
        step();
        n_checks++;
        if (Busy !== 1'b1 || SSP_RA !== 3'd6 || Gnt !== 2'b01)
            $display("FAIL b2b_setup: busy %b ra %0d gnt %b want 1 6 01", Busy, SSP_RA, Gnt);
        else
            n_pass++;
        Req0 = 1'b0;
        wait_ack(10, k, who);
        e = sb.pop_front();
        n_checks++;
        if (k + 1 !== 5 || who !== int'(e.who) || RdData !== e.rd)
            $display("FAIL b2b_second: lat %0d who %0d rd %h want 5 %0d %h", k + 1, who, RdData, e.who, e.rd);
        else
            n_pass++;
        step();
    endtask

    task automatic test_wait4();
        int k = 0;
        int cyc0;
        exp_t e;
        pulse_reset();
        cyc0 = cyc;
        Req1 = 1'b1; WnR1 = 1'b0; RA1 = 3'd2;
        sb.push_back('{who: 1'b1, rd: 12'(cyc0 + 6)});
        step();
        k++;
        Req1 = 1'b0;
        while (!(Ack0_4 || Ack1_4) && k < 14) begin
            step();
            k++;
        end
        e = sb.pop_front();
        n_checks++;
        if (k !== 7 || Ack1_4 !== e.who || RdData_4 !== e.rd)
            $display("FAIL wait4: lat %0d ack1 %b rd %h want 7 %b %h", k, Ack1_4, RdData_4, e.who, e.rd);
        else
            n_pass++;
        step();
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (viol !== 0)
            $display("FAIL exclusive: %0d cycles with dual ack or gnt 11, want 0", viol);
        else
            n_pass++;
        n_checks++;
        if (sb.size() !== 0)
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_reset_abort();
        test_back_to_back();
        test_wait4();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
